// File: rtl/bin_pkg.sv
// Shared types for the binarization engine: threshold modes,
// FSM state encoding and status LED codes.
package bin_pkg;

    typedef enum logic [1:0] {
        MODE_FIX   = 2'b00,
        MODE_INV   = 2'b01,
        MODE_BAND  = 2'b10,
        MODE_IBAND = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] LED_IDLE = 2'b00;
    localparam logic [1:0] LED_INIT = 2'b01;
    localparam logic [1:0] LED_RUN  = 2'b10;
    localparam logic [1:0] LED_DONE = 2'b11;

endpackage

// File: rtl/bin_compare.sv
// Combinational pixel threshold test for the four binarization modes.
// All comparisons are unsigned.
module bin_compare
    import bin_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] i_pix,
    input  logic [PIX_W-1:0] i_thr_lo,
    input  logic [PIX_W-1:0] i_thr_hi,
    input  mode_e            i_mode,
    output logic             o_bit
);

    logic w_ge;
    logic w_band;

    // An inverted range (lo > hi) leaves w_band empty by construction.
    assign w_ge   = (i_pix >= i_thr_lo);
    assign w_band = w_ge & (i_pix <= i_thr_hi);

    always_comb begin
        o_bit = 1'b0;
        unique case (i_mode)
            MODE_FIX:   o_bit = w_ge;
            MODE_INV:   o_bit = ~w_ge;
            MODE_BAND:  o_bit = w_band;
            MODE_IBAND: o_bit = ~w_band;
        endcase
    end

endmodule

// File: rtl/binarization_engine.sv
// Streams a grayscale frame from pixel RAM into a 1-bit mask RAM.
// Optional foreground counter enabled by defining BIN_FG_COUNT_EN.
module binarization_engine
    import bin_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 16,
    parameter int IMG_PIXELS = 65536,
    parameter int RD_LAT     = 1
) (
    input  logic              bin_clk,
    input  logic              bin_rst,
    input  logic              int_ctrl,
    input  logic              bin_ctrl,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  thr_lo,
    input  logic [PIX_W-1:0]  thr_hi,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              bin_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        condition_led
`ifdef BIN_FG_COUNT_EN
    ,
    output logic [ADDR_W:0]   fg_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_PIXELS - 1);

    state_e            r_state;
    state_e            w_next;
    logic              r_int_q, r_int_d;
    logic              r_bin_q, r_bin_d;
    logic              w_int_rise, w_bin_rise;
    logic              w_acc_int, w_acc_bin;
    logic [ADDR_W-1:0] r_addr;
    mode_e             r_mode;
    logic [PIX_W-1:0]  r_lo, r_hi;
    logic [RD_LAT-1:0] r_pv;
    logic [ADDR_W-1:0] r_pa [RD_LAT];
    logic              r_wr_en;
    logic              r_bin;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [1:0]        r_led;
    logic              w_cmp;

    // Edges seen while busy are consumed here and never replayed.
    assign w_int_rise = r_int_q & ~r_int_d;
    assign w_bin_rise = r_bin_q & ~r_bin_d;
    assign w_acc_int  = (r_state == ST_IDLE) & w_int_rise;
    assign w_acc_bin  = (r_state == ST_IDLE) & w_bin_rise & ~w_int_rise;

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst) begin
            r_int_q <= 1'b0;
            r_int_d <= 1'b0;
            r_bin_q <= 1'b0;
            r_bin_d <= 1'b0;
        end else begin
            r_int_q <= int_ctrl;
            r_int_d <= r_int_q;
            r_bin_q <= bin_ctrl;
            r_bin_d <= r_bin_q;
        end
    end

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        rd_en         = 1'b0;
        rd_addr       = '0;
        wr_en         = r_wr_en;
        wr_addr       = r_wr_en ? r_wr_addr : '0;
        bin_data      = r_wr_en & r_bin;
        busy          = 1'b0;
        done          = 1'b0;
        condition_led = r_led;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc_int)      w_next = ST_INIT;
                else if (w_acc_bin) w_next = ST_RUN;
            end
            ST_INIT: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                wr_addr  = r_addr;
                bin_data = 1'b0;
                if (r_addr == LAST) w_next = ST_DONE;
            end
            ST_RUN: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = r_addr;
                if (r_addr == LAST) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_wr_en && (r_wr_addr == LAST)) w_next = ST_DONE;
            end
            ST_DONE: begin
                done          = 1'b1;
                condition_led = LED_DONE;
                w_next        = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst) begin
            r_addr <= '0;
        end else if (w_acc_int || w_acc_bin) begin
            r_addr <= '0;
        end else if ((r_state == ST_INIT || r_state == ST_RUN)
                     && (r_addr != LAST)) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst) begin
            r_mode <= MODE_FIX;
            r_lo   <= '0;
            r_hi   <= '0;
        end else if (w_acc_bin) begin
            r_mode <= mode_e'(mode);
            r_lo   <= thr_lo;
            r_hi   <= thr_hi;
        end
    end

    // The last pipeline stage lines up with rd_data for that address.
    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst) begin
            r_pv      <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pa[i] <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_bin     <= 1'b0;
        end else begin
            r_pv[0] <= (r_state == ST_RUN);
            r_pa[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
            r_wr_en   <= r_pv[RD_LAT-1];
            r_wr_addr <= r_pa[RD_LAT-1];
            r_bin     <= w_cmp;
        end
    end

    bin_compare #(
        .PIX_W (PIX_W)
    ) u_cmp (
        .i_pix    (rd_data),
        .i_thr_lo (r_lo),
        .i_thr_hi (r_hi),
        .i_mode   (r_mode),
        .o_bit    (w_cmp)
    );

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst)                r_led <= LED_IDLE;
        else if (w_acc_int)         r_led <= LED_INIT;
        else if (w_acc_bin)         r_led <= LED_RUN;
        else if (r_state == ST_DONE) r_led <= LED_DONE;
    end

`ifdef BIN_FG_COUNT_EN
    logic [ADDR_W:0] r_fg;

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst)               r_fg <= '0;
        else if (w_acc_bin)        r_fg <= '0;
        else if (r_wr_en && r_bin) r_fg <= r_fg + (ADDR_W+1)'(1);
    end

    assign fg_count = r_fg;
`endif

endmodule

// File: tb/tb_binarization_engine.sv
// Directed bench: 16-pixel frame, read latency 2, pixel[i] = i*16.
// Table-driven threshold passes plus INIT, command-race and reset cases.
module tb_binarization_engine;

    localparam int N = 16;
    localparam int L = 2;

    logic        bin_clk = 1'b0;
    logic        bin_rst = 1'b1;
    logic        int_ctrl = 1'b0;
    logic        bin_ctrl = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  thr_lo = 8'd0;
    logic [7:0]  thr_hi = 8'd0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic        bin_data;
    logic        busy;
    logic        done;
    logic [1:0]  condition_led;
`ifdef BIN_FG_COUNT_EN
    logic [16:0] fg_count;
`endif

    binarization_engine #(
        .PIX_W      (8),
        .ADDR_W     (16),
        .IMG_PIXELS (N),
        .RD_LAT     (L)
    ) dut (
        .bin_clk       (bin_clk),
        .bin_rst       (bin_rst),
        .int_ctrl      (int_ctrl),
        .bin_ctrl      (bin_ctrl),
        .mode          (mode),
        .thr_lo        (thr_lo),
        .thr_hi        (thr_hi),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .bin_data      (bin_data),
        .busy          (busy),
        .done          (done),
        .condition_led (condition_led)
`ifdef BIN_FG_COUNT_EN
        ,
        .fg_count      (fg_count)
`endif
    );

    always #5 bin_clk = ~bin_clk;

    // Pixel RAM with two-cycle read latency.
    logic [7:0] p1;
    always @(posedge bin_clk) begin
        p1      <= rd_en ? 8'(rd_addr << 4) : 8'h00;
        rd_data <= p1;
    end

    // Write log and event counters.
    int          cyc = 0;
    int          wcnt = 0;
    int          rdcnt = 0;
    int          dcnt = 0;
    logic [15:0] la [512];
    logic        lb [512];
    int          lc [512];

    always @(posedge bin_clk) begin
        cyc <= cyc + 1;
        if (wr_en && wcnt < 512) begin
            la[wcnt] <= wr_addr;
            lb[wcnt] <= bin_data;
            lc[wcnt] <= cyc;
            wcnt     <= wcnt + 1;
        end
        if (rd_en) rdcnt <= rdcnt + 1;
        if (done)  dcnt  <= dcnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_log(input string nm, input int base,
                           input logic [15:0] exp);
        logic [15:0] m;
        int bad;
        m   = '0;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            m[k] = lb[base+k];
            if (la[base+k] !== 16'(k)) bad++;
            if (lc[base+k] != lc[base] + k) bad++;
        end
        chk({nm, " mask"}, 64'(m), 64'(exp));
        chk({nm, " addr/gap"}, 64'(bad), 64'd0);
    endtask

    // Starts a binarize pass and follows it to done; pulse_at >= 0 adds
    // a second bin_ctrl pulse that lands mid-run.
    task automatic run_bin(input logic [1:0] m, input logic [7:0] lo,
                           input logic [7:0] hi, input int pulse_at,
                           output int t_rd, output int t_done);
        t_rd   = -1;
        t_done = -1;
        @(negedge bin_clk);
        mode     = m;
        thr_lo   = lo;
        thr_hi   = hi;
        bin_ctrl = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge bin_clk);
            if (k == 3) bin_ctrl = 1'b0;
            if (k == pulse_at) bin_ctrl = 1'b1;
            if (k == pulse_at + 2) bin_ctrl = 1'b0;
            if (rd_en && t_rd < 0) t_rd = cyc;
            if (done) begin
                t_done = cyc;
                break;
            end
        end
        bin_ctrl = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] mask;
        int          fg;
    } vec_t;

    vec_t tv [9];

    initial begin
        int base, r0, d0, t_rd, t_done, found;
        logic [1:0] led_mid;

        tv[0] = '{2'b00, 8'd128, 8'd0,   16'hFF00, 8};
        tv[1] = '{2'b10, 8'd64,  8'd160, 16'h07F0, 7};
        tv[2] = '{2'b11, 8'd64,  8'd160, 16'hF80F, 9};
        tv[3] = '{2'b10, 8'd200, 8'd100, 16'h0000, 0};
        tv[4] = '{2'b11, 8'd200, 8'd100, 16'hFFFF, 16};
        tv[5] = '{2'b01, 8'd128, 8'd0,   16'h00FF, 8};
        tv[6] = '{2'b00, 8'd0,   8'd0,   16'hFFFF, 16};
        tv[7] = '{2'b00, 8'd255, 8'd0,   16'h0000, 0};
        tv[8] = '{2'b10, 8'd80,  8'd80,  16'h0020, 1};

        // Reset state
        repeat (3) @(negedge bin_clk);
        chk("reset outputs",
            64'({rd_en, wr_en, bin_data, busy, done, condition_led}), 64'd0);
        chk("reset addrs", 64'({rd_addr, wr_addr}), 64'd0);
        bin_rst = 1'b0;
        repeat (3) @(negedge bin_clk);

        // INIT with a long command level
        base     = wcnt;
        r0       = rdcnt;
        d0       = dcnt;
        led_mid  = 2'b00;
        t_done   = -1;
        int_ctrl = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge bin_clk);
            if (k == 10) int_ctrl = 1'b0;
            if (k == 5) led_mid = condition_led;
            if (done) begin
                t_done = cyc;
                break;
            end
        end
        int_ctrl = 1'b0;
        chk("init done seen", 64'(t_done >= 0), 64'd1);
        chk("init led during", 64'(led_mid), 64'd1);
        chk("init led done", 64'(condition_led), 64'd3);
        repeat (25) @(negedge bin_clk);
        chk("init wr count", 64'(wcnt - base), 64'(N));
        chk_log("init", base, 16'h0000);
        chk("init no rd", 64'(rdcnt - r0), 64'd0);
        chk("init done once", 64'(dcnt - d0), 64'd1);
        chk("init led held", 64'(condition_led), 64'd3);

        // Threshold table
        for (int v = 0; v < 9; v++) begin
            base = wcnt;
            run_bin(tv[v].m, tv[v].lo, tv[v].hi, -10, t_rd, t_done);
            chk($sformatf("v%0d done", v), 64'(t_done >= 0), 64'd1);
            chk($sformatf("v%0d pass len", v), 64'(t_done - t_rd),
                64'(N + L + 1));
            chk($sformatf("v%0d led", v), 64'(condition_led), 64'd3);
            @(negedge bin_clk);
            chk($sformatf("v%0d wr count", v), 64'(wcnt - base), 64'(N));
            chk($sformatf("v%0d wr lat", v), 64'(lc[base] - t_rd),
                64'(L + 1));
            chk_log($sformatf("v%0d", v), base, tv[v].mask);
            chk($sformatf("v%0d idle", v), 64'({busy, done}), 64'd0);
`ifdef BIN_FG_COUNT_EN
            chk($sformatf("v%0d fg", v), 64'(fg_count), 64'(tv[v].fg));
`endif
        end

        // Mid-run bin_ctrl pulse is ignored
        base = wcnt;
        r0   = rdcnt;
        d0   = dcnt;
        run_bin(2'b00, 8'd128, 8'd0, 8, t_rd, t_done);
        repeat (30) @(negedge bin_clk);
        chk("midpulse rd count", 64'(rdcnt - r0), 64'(N));
        chk("midpulse wr count", 64'(wcnt - base), 64'(N));
        chk("midpulse done once", 64'(dcnt - d0), 64'd1);
        chk_log("midpulse", base, 16'hFF00);

        // Simultaneous int+bin edges: INIT only
        base = wcnt;
        r0   = rdcnt;
        d0   = dcnt;
        t_done = -1;
        int_ctrl = 1'b1;
        bin_ctrl = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge bin_clk);
            if (k == 3) begin
                int_ctrl = 1'b0;
                bin_ctrl = 1'b0;
            end
            if (done) begin
                t_done = cyc;
                break;
            end
        end
        int_ctrl = 1'b0;
        bin_ctrl = 1'b0;
        repeat (25) @(negedge bin_clk);
        chk("race done seen", 64'(t_done >= 0), 64'd1);
        chk("race no rd", 64'(rdcnt - r0), 64'd0);
        chk("race wr count", 64'(wcnt - base), 64'(N));
        chk_log("race", base, 16'h0000);
        chk("race done once", 64'(dcnt - d0), 64'd1);

        // Reset at write 5 of a RUN pass
        base  = wcnt;
        found = 0;
        @(negedge bin_clk);
        mode     = 2'b00;
        thr_lo   = 8'd0;
        bin_ctrl = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge bin_clk);
            if (k == 3) bin_ctrl = 1'b0;
            if (wr_en && wr_addr == 16'd5) begin
                found = 1;
                break;
            end
        end
        bin_ctrl = 1'b0;
        chk("rst write5 reached", 64'(found), 64'd1);
        bin_rst = 1'b1;
        #1;
        chk("rst outputs",
            64'({rd_en, wr_en, bin_data, busy, done, condition_led}), 64'd0);
        chk("rst addrs", 64'({rd_addr, wr_addr}), 64'd0);
`ifdef BIN_FG_COUNT_EN
        chk("rst fg", 64'(fg_count), 64'd0);
`endif
        repeat (2) @(negedge bin_clk);
        bin_rst = 1'b0;
        r0 = rdcnt;
        d0 = dcnt;
        repeat (30) @(negedge bin_clk);
        chk("rst wr total", 64'(wcnt - base), 64'd5);
        chk("rst no rd after", 64'(rdcnt - r0), 64'd0);
        chk("rst no done", 64'(dcnt - d0), 64'd0);
        chk("rst led idle", 64'(condition_led), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
